imem_loader: RTL and testbench

//  Writer side of the instruction-memory port: receives a program as a byte

---
 rtl/imem_loader.sv | 140 ++++++++++++++
 tb/tb_imem_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a little-endian byte stream (word count N,
// then N words) into 32-bit IM writes at word addresses 0..N-1, holding the CPU in reset until loaded.
module imem_loader #(
  parameter int          ADDR_W = 8,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         asm_q, asm_d;
  logic [31:0]         n_q, n_d;
  logic [ADDR_W:0]     addr_q, addr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic                accept;
  logic                last_byte;
  logic [31:0]         word;
  logic [ADDR_W:0]     addr_inc;
  logic                last_word;

  assign accept    = rx_valid & rx_ready;
  assign last_byte = accept && (byte_cnt_q == 2'd3);
  // Little-endian: bytes shift in from the top, so the first lands in [7:0].
  assign word      = {rx_data, asm_q};
  assign addr_inc  = addr_q + 1'b1;
  // addr is one bit wider than the IM address so N == DEPTH still terminates.
  assign last_word = (32'(addr_inc) == n_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN;
      S_LEN: if (last_byte) begin
        if (word == 32'd0)      state_d = S_DONE;
        else if (word > DEPTH)  state_d = S_ERR;
        else                    state_d = S_DATA;
      end
      S_DATA:  if (last_byte) state_d = S_WRITE;
      S_WRITE: state_d = last_word ? S_DONE : S_DATA;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    n_d        = n_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if ((state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR) && start) begin
      byte_cnt_d = 2'd0;
      asm_d      = 24'd0;
      addr_d     = '0;
    end
    if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      asm_d      = word[31:8];
    end
    if (state_q == S_LEN && last_byte) n_d = word;
    if (state_q == S_DATA && last_byte) begin
      we_d    = 1'b1;
      waddr_d = addr_q[ADDR_W-1:0];
      wdata_d = word;
    end
    if (state_q == S_WRITE) addr_d = addr_inc;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      byte_cnt_q <= 2'd0;
      asm_q      <= 24'd0;
      n_q        <= 32'd0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state_q)
      S_LEN, S_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      S_WRITE: busy = 1'b1;
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader (ADDR_W=4): directed images, expected IM writes queued
// as each word is sent and popped by a monitor whenever we is high.
module tb_imem_loader;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready, we, busy, done, error, cpu_hold;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  int checks = 0;
  int passed = 0;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] exp_e;
  logic [31:0]    img[$];

  imem_loader #(.ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata), .busy(busy),
    .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    $display("FAIL %s: timed out", name);
  endtask

  // Scoreboard monitor: every write must match the next queued expectation.
  always @(negedge CLK) begin
    if (!RST && we) begin
      chk("we_with_rx_ready", 32'(rx_ready), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got waddr=%0d wdata=0x%0h required no write", waddr, wdata);
      end else begin
        exp_e = exp_q.pop_front();
        chk("waddr", 32'(waddr), 32'(exp_e[AW+31:32]));
        chk("wdata", wdata, exp_e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    rx_valid = 1'b0;
    repeat (gap) @(negedge CLK);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (!rx_ready) begin
      timeout_fail("byte_accept");
      rx_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], rnd ? int'($urandom_range(0, 7)) : 0);
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (busy) timeout_fail("load_finish");
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load(input bit rnd);
    pulse_start();
    send_word(32'(img.size()), rnd);
    for (int i = 0; i < img.size(); i++) begin
      exp_q.push_back({AW'(i), img[i]});
      send_word(img[i], rnd);
    end
    wait_idle();
  endtask

  initial begin
    #2;
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    @(negedge CLK);
    RST = 1'b0;

    // Two-word program, gap-free
    img = '{32'h0000_0013, 32'h0010_0093};
    load(1'b0);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("t1_error", 32'(error), 32'd0);

    // Empty image goes straight to DONE
    pulse_start();
    chk("t2_hold_in_len", 32'(cpu_hold), 32'd1);
    chk("t2_busy_in_len", 32'(busy), 32'd1);
    send_word(32'd0, 1'b0);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_cpu_hold", 32'(cpu_hold), 32'd0);

    // Oversize header -> ERR, then recovery
    pulse_start();
    send_word(32'd17, 1'b0);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("t3_rx_ready", 32'(rx_ready), 32'd0);
    chk("t3_done", 32'(done), 32'd0);
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    repeat (4) @(negedge CLK);
    chk("t3_rx_ready_held", 32'(rx_ready), 32'd0);
    rx_valid = 1'b0;
    img = '{32'hDEAD_BEEF};
    load(1'b0);
    chk("t3_done_after", 32'(done), 32'd1);
    chk("t3_error_after", 32'(error), 32'd0);

    // Full-depth image: 16 writes, none beyond
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(32'hA500_0000 + 32'(i) * 32'h0001_0101);
    load(1'b0);
    repeat (5) @(negedge CLK);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_last_waddr", 32'(waddr), 32'd15);
    chk("t4_no_extra", 32'(exp_q.size()), 32'd0);

    // Random rx_valid gaps
    img = '{32'h1234_5678, 32'h8765_4321, 32'hFFFF_0001};
    load(1'b1);
    chk("t5_done", 32'(done), 32'd1);

    // Reset in the middle of the first data word
    pulse_start();
    send_word(32'd2, 1'b0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #2 RST = 1'b1;
    #1;
    chk("t6_we", 32'(we), 32'd0);
    chk("t6_waddr", 32'(waddr), 32'd0);
    chk("t6_wdata", wdata, 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rx_ready", 32'(rx_ready), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_cpu_hold", 32'(cpu_hold), 32'd1);
    @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
    img = '{32'hCAFE_0001, 32'hCAFE_0002};
    load(1'b0);
    chk("t6_done_after", 32'(done), 32'd1);
    chk("t6_waddr_after", 32'(waddr), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
